// File: rtl/umul_bi_seq.sv
// Sequencer for one bipolar unary multiplier: load B, stream A, count ones.
// Optional UMUL_BI_SEQ_SIGNED_EN adds the two's complement bipolar result.
module umul_bi_seq #(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iStart,
  input  logic [BITWIDTH-1:0] iOpA,
  input  logic [BITWIDTH-1:0] iOpB,
  output logic                oReady,
  output logic                oA,
  output logic [BITWIDTH-1:0] oB,
  output logic                oLoadB,
  output logic                oClr,
  input  logic                iMult,
  output logic                oDone,
`ifdef UMUL_BI_SEQ_SIGNED_EN
  output logic [BITWIDTH+1:0] oResultBi,
`endif
  output logic [BITWIDTH:0]   oCount
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t              state;
  logic [BITWIDTH-1:0] op_a;
  logic [BITWIDTH-1:0] op_b;
  logic [BITWIDTH-1:0] cnt;
  logic [BITWIDTH-1:0] cnt_nxt;
  logic                last;
  logic [BITWIDTH:0]   count_nxt;

  // van der Corput index: bit-reversed run counter
  function automatic logic [BITWIDTH-1:0] bitrev(
    input logic [BITWIDTH-1:0] v
  );
    logic [BITWIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < BITWIDTH; i++) begin
      r[i] = v[BITWIDTH-1-i];
    end
    return r;
  endfunction

  assign cnt_nxt   = cnt + 1'b1;
  assign last      = &cnt;
  assign count_nxt = oCount + {{BITWIDTH{1'b0}}, iMult};
  assign oB        = op_b;

`ifdef UMUL_BI_SEQ_SIGNED_EN
  localparam logic [BITWIDTH+1:0] RES_MIN =
    {2'b11, {BITWIDTH{1'b0}}};
  localparam logic [BITWIDTH+1:0] RES_OFS =
    {2'b01, {BITWIDTH{1'b0}}};
`endif

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      cnt    <= '0;
      oReady <= 1'b1;
      oA     <= 1'b0;
      oLoadB <= 1'b0;
      oClr   <= 1'b0;
      oDone  <= 1'b0;
      oCount <= '0;
`ifdef UMUL_BI_SEQ_SIGNED_EN
      oResultBi <= RES_MIN;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (iStart) begin
            op_a   <= iOpA;
            op_b   <= iOpB;
            cnt    <= '0;
            oCount <= '0;
`ifdef UMUL_BI_SEQ_SIGNED_EN
            oResultBi <= RES_MIN;
`endif
            oReady <= 1'b0;
            oLoadB <= 1'b1;
            oClr   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          oLoadB <= 1'b0;
          oClr   <= 1'b0;
          oA     <= op_a > bitrev(cnt);
          state  <= RUN;
        end
        RUN: begin
          oCount <= count_nxt;
`ifdef UMUL_BI_SEQ_SIGNED_EN
          oResultBi <= {count_nxt, 1'b0} - RES_OFS;
`endif
          cnt <= cnt_nxt;
          if (last) begin
            oA    <= 1'b0;
            oDone <= 1'b1;
            state <= DONE;
          end else begin
            oA <= op_a > bitrev(cnt_nxt);
          end
        end
        DONE: begin
          oDone  <= 1'b0;
          oReady <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_umul_bi_seq.sv
// Scoreboard bench for umul_bi_seq: directed runs, stub and model multipliers.
// Define UMUL_BI_SEQ_SIGNED_EN to also check oResultBi.
module tb_umul_bi_seq;

  logic       iClk = 1'b0;
  logic       iRstN;
  logic       iStart;
  logic [7:0] iOpA;
  logic [7:0] iOpB;
  logic       oReady;
  logic       oA;
  logic [7:0] oB;
  logic       oLoadB;
  logic       oClr;
  logic       iMult;
  logic       oDone;
  logic [8:0] oCount;
`ifdef UMUL_BI_SEQ_SIGNED_EN
  logic [9:0] oResultBi;
`endif

  umul_bi_seq #(.BITWIDTH(8)) dut (
    .iClk(iClk),
    .iRstN(iRstN),
    .iStart(iStart),
    .iOpA(iOpA),
    .iOpB(iOpB),
    .oReady(oReady),
    .oA(oA),
    .oB(oB),
    .oLoadB(oLoadB),
    .oClr(oClr),
    .iMult(iMult),
    .oDone(oDone),
`ifdef UMUL_BI_SEQ_SIGNED_EN
    .oResultBi(oResultBi),
`endif
    .oCount(oCount)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int cnt;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   a_hi = 0;
  int   ld_hi = 0;
  int   clr_hi = 0;
  int   mode = 1;

  // reference multiplier: counter RNG, B comparator, bipolar XNOR
  logic [7:0] mb = '0;
  logic [7:0] mrng = '0;

  always @(posedge iClk) begin
    if (oLoadB) mb <= oB;
    if (oClr) mrng <= '0;
    else mrng <= mrng + 8'd1;
  end

  always_comb begin
    iMult = 1'b0;
    case (mode)
      0: iMult = 1'b1;
      1: iMult = oA;
      default: iMult = ~(oA ^ (mb > mrng));
    endcase
  end

  always @(posedge iClk) cyc = cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  always @(negedge iClk) begin
    if (iRstN) begin
      if (oA) a_hi++;
      if (oLoadB) ld_hi++;
      if (oClr) clr_hi++;
    end
  end

  always @(negedge iClk) begin
    exp_t e;
    if (iRstN && oDone) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("count", int'(oCount), e.cnt);
        chk("done_cycle", cyc, e.cyc);
`ifdef UMUL_BI_SEQ_SIGNED_EN
        chk("result_bi", int'($signed(oResultBi)), 2 * e.cnt - 256);
`endif
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input int exp_cnt, input bit hold,
                       output int acc);
    int n;
    n = 0;
    @(negedge iClk);
    while (!oReady && n < 1000) begin
      @(negedge iClk);
      n++;
    end
    chk("ready_wait", int'(oReady), 1);
    iStart = 1'b1;
    iOpA = a;
    iOpB = b;
    acc = cyc + 1;
    sb.push_back('{cnt: exp_cnt, cyc: acc + 257});
    @(posedge iClk);
    #1;
    if (!hold) iStart = 1'b0;
    a_hi = 0;
    ld_hi = 0;
    clr_hi = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge iClk);
      #1;
      n++;
    end
    chk("done_timeout", sb.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc2;
    int n;
    iRstN = 1'b0;
    iStart = 1'b0;
    iOpA = '0;
    iOpB = '0;
    repeat (3) @(negedge iClk);
    chk("rst_ready", int'(oReady), 1);
    chk("rst_a", int'(oA), 0);
    chk("rst_loadb", int'(oLoadB), 0);
    chk("rst_clr", int'(oClr), 0);
    chk("rst_done", int'(oDone), 0);
    chk("rst_count", int'(oCount), 0);
    chk("rst_b", int'(oB), 0);
    iRstN = 1'b1;

    mode = 0;
    issue(8'd37, 8'd201, 256, 1'b0, acc);
    wait_done();

    mode = 1;
    issue(8'd200, 8'd93, 200, 1'b0, acc);
    wait_done();
    chk("a_ones", a_hi, 200);
    chk("loadb_cycles", ld_hi, 1);
    chk("clr_cycles", clr_hi, 1);
    chk("ob", int'(oB), 93);

    issue(8'd0, 8'd5, 0, 1'b0, acc);
    wait_done();
    chk("a_ones_min", a_hi, 0);
    issue(8'd255, 8'd5, 255, 1'b0, acc);
    wait_done();
    chk("a_ones_max", a_hi, 255);

    mode = 2;
    issue(8'd0, 8'd0, 256, 1'b0, acc);
    wait_done();
    issue(8'd0, 8'd128, 128, 1'b0, acc);
    wait_done();

    mode = 1;
    issue(8'd150, 8'd7, 150, 1'b1, acc);
    repeat (20) @(negedge iClk);
    iOpA = 8'd10;
    iOpB = 8'd3;
    n = 0;
    @(negedge iClk);
    while (!oReady && n < 400) begin
      @(negedge iClk);
      n++;
    end
    chk("b2b_ready", int'(oReady), 1);
    acc2 = cyc + 1;
    chk("b2b_accept", acc2, acc + 259);
    sb.push_back('{cnt: 10, cyc: acc2 + 257});
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    wait_done();
    chk("b2b_ob", int'(oB), 3);
    repeat (5) @(negedge iClk);
    chk("no_extra_run", int'(oReady), 1);

    issue(8'd120, 8'd44, 120, 1'b0, acc);
    repeat (51) @(posedge iClk);
    #2;
    chk("pre_rst_count", int'(oCount > 9'd0), 1);
    iRstN = 1'b0;
    #1;
    chk("abort_ready", int'(oReady), 1);
    chk("abort_a", int'(oA), 0);
    chk("abort_loadb", int'(oLoadB), 0);
    chk("abort_clr", int'(oClr), 0);
    chk("abort_done", int'(oDone), 0);
    chk("abort_count", int'(oCount), 0);
    chk("abort_b", int'(oB), 0);
`ifdef UMUL_BI_SEQ_SIGNED_EN
    chk("abort_result_bi", int'($signed(oResultBi)), -256);
`endif
    sb.delete();
    @(negedge iClk);
    iRstN = 1'b1;
    issue(8'd77, 8'd9, 77, 1'b0, acc);
    wait_done();

    repeat (3) @(negedge iClk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
